secuenciador: RTL and testbench
===============================

SECUENCIADOR -- requirements
Module: secuenciador

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter IW, default 20, meaning instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning an instruction is offered.
REQ-006 SHALL have port in_instr, input, IW, meaning the offered instruction.
REQ-007 SHALL have port in_ready, output, 1, high when the queue is not full.
REQ-008 SHALL have port start, input, 1, meaning run the queued program.
REQ-009 SHALL have port instruccion, output, IW, the word driven to the datapath.
REQ-010 SHALL have port instr_valid, output, 1, meaning instruccion is issued this cycle.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse at program end.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, meaning queue occupancy.
REQ-014 SHALL have port issued, output, 8, meaning the running count of issued instructions.

Function
REQ-015 SHALL push in_instr when in_valid and in_ready; push while full SHALL be ignored, with no count change.
REQ-016 SHALL allow push and pop in the same cycle, leaving count unchanged.
REQ-017 SHALL wrap read/write pointers modulo DEPTH.
REQ-018 SHALL implement FSM states IDLE, LOAD, STALL, ISSUE, FIN.
REQ-019 IDLE: when start=1 and count>0, SHALL go to LOAD; start with count=0 SHALL be ignored.
REQ-020 LOAD: SHALL pop the head into register cur and go to ISSUE, or to STALL per REQ-028.
REQ-021 ISSUE: SHALL set instruccion=cur and instr_valid=1 for exactly one cycle; next state is LOAD if count>0, else FIN.
REQ-022 FIN: SHALL set done=1 for one cycle, then go to IDLE.
REQ-023 In every state except ISSUE, bits 19 (WE_B) and 3 (WE_A) of instruccion SHALL be 0 and instr_valid SHALL be 0; in IDLE instruccion SHALL be all zero.
REQ-024 SHALL ignore start while busy=1; pushes SHALL remain accepted while busy.
REQ-025 Timing: start sampled at edge N gives LOAD at N+1 and first ISSUE at N+2; steady state is one issue per 2 cycles.
REQ-026 issued SHALL increment on each ISSUE cycle and wrap 255->0.

Reset
REQ-027 rst=1 SHALL, at the next edge and regardless of state, force IDLE, empty the queue, clear cur and issued, and drive all outputs 0 except in_ready=1.

Configuration
REQ-028 Macro SECUENCIADOR_HAZARD_EN: when defined, LOAD SHALL go to STALL for one cycle if the popped instruction's [18:14] or [13:9] equals the previously issued [8:4] and that instruction had bit 3=1; STALL then goes to ISSUE.
REQ-029 When SECUENCIADOR_HAZARD_EN is undefined, STALL SHALL be unreachable and LOAD SHALL always go to ISSUE.

Structure
REQ-030 Package secuenciador_pkg SHALL hold the state enum and instruction field constants: WE_B=19, DL1=18:14, DL2=13:9, DE=8:4, WE_A=3, SEL=2:0, IW=20.
REQ-031 The queue SHALL be a sub-module cola_instr (synchronous FIFO with push/pop/full/empty/count).

Verification
REQ-032 Push 3 instructions, then pulse start: exactly 3 ISSUE cycles at N+2, N+4, N+6; done at N+7; issued=3.
REQ-033 Push 9 instructions with DEPTH=8: in_ready=0 after the 8th, the 9th is dropped, count=8.
REQ-034 Push 0x0_0018 (WE_A=1, DE=1), then 0x0_4000 (DL1=1): with the macro, one STALL cycle with WE bits 0; without it, ISSUEs 2 cycles apart.
REQ-035 Assert rst during ISSUE of the 2nd of 4 instructions: next cycle IDLE, count=0, instruccion=0, issued=0, no done pulse.
REQ-036 Issue 256 instructions: issued wraps to 0; a start pulse while busy has no effect.

Source files
------------

// File: rtl/secuenciador_pkg.sv
// Shared types and instruction field layout for the secuenciador block.
// Field map (20-bit word): WE_B | DL1 | DL2 | DE | WE_A | SEL
package secuenciador_pkg;

  localparam int IW     = 20;
  localparam int WE_B   = 19;
  localparam int DL1_HI = 18;
  localparam int DL1_LO = 14;
  localparam int DL2_HI = 13;
  localparam int DL2_LO = 9;
  localparam int DE_HI  = 8;
  localparam int DE_LO  = 4;
  localparam int WE_A   = 3;
  localparam int SEL_HI = 2;
  localparam int SEL_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STALL,
    ST_ISSUE,
    ST_FIN
  } state_e;

  // Read-after-write clash: the next word reads a register the previous word wrote via port A.
  function automatic logic raw_hazard(input logic [IW-1:0] nxt, input logic [IW-1:0] prv);
    return prv[WE_A] &&
           ((nxt[DL1_HI:DL1_LO] == prv[DE_HI:DE_LO]) ||
            (nxt[DL2_HI:DL2_LO] == prv[DE_HI:DE_LO]));
  endfunction

endpackage

// File: rtl/secuenciador_cola_instr.sv
// cola_instr: synchronous instruction FIFO with occupancy count.
// A push while full is dropped; a pop while empty is ignored.
module cola_instr #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/secuenciador.sv
// secuenciador: queues instruction words and, on start, issues them one by one to the datapath.
// Optional macro SECUENCIADOR_HAZARD_EN inserts a one-cycle stall on a read-after-write clash.
//
// state    | meaning
// IDLE     | waiting for start with a non-empty queue; outputs all zero
// LOAD     | pop queue head into cur
// STALL    | one bubble for a RAW clash (only with SECUENCIADOR_HAZARD_EN)
// ISSUE    | drive cur with instr_valid for one cycle
// FIN      | one-cycle done pulse, back to IDLE
module secuenciador
  import secuenciador_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [IW-1:0]          in_instr,
  output logic                   in_ready,
  input  logic                   start,
  output logic [IW-1:0]          instruccion,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             issued
);

  logic                   fifo_full, fifo_empty, pop;
  logic [IW-1:0]          fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  state_e                 state_q, state_d;
  logic [IW-1:0]          cur_q, cur_d;
  logic [7:0]             issued_q, issued_d;
  logic                   load_hazard;

  cola_instr #(.DEPTH(DEPTH), .W(IW)) u_cola (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (pop),
    .din_i   (in_instr),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign count    = fifo_count;
  assign issued   = issued_q;

`ifdef SECUENCIADOR_HAZARD_EN
  logic [IW-1:0] prev_q;

  assign load_hazard = raw_hazard(fifo_head, prev_q);

  // Remember the last issued word so the next load can be checked against it.
  always_ff @(posedge clk) begin
    if (rst)                       prev_q <= '0;
    else if (state_q == ST_ISSUE)  prev_q <= cur_q;
  end
`else
  assign load_hazard = 1'b0;
`endif

  // Next-state and output decode; outputs stay zero outside ISSUE so WE bits never leak.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    issued_d    = issued_q;
    pop         = 1'b0;
    instruccion = '0;
    instr_valid = 1'b0;
    done        = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start && !fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop     = !fifo_empty;
        cur_d   = fifo_head;
        state_d = load_hazard ? ST_STALL : ST_ISSUE;
      end
      ST_STALL: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        instruccion = cur_q;
        instr_valid = 1'b1;
        issued_d    = issued_q + 8'd1;
        state_d     = fifo_empty ? ST_FIN : ST_LOAD;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, current word and issue counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_secuenciador.sv
// Testbench for secuenciador: directed table, multi-cycle corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_secuenciador;

  localparam int DEPTH = 8;
  localparam int IW    = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_instr = '0;
  logic          start = 1'b0;
  logic          in_ready, instr_valid, busy, done;
  logic [IW-1:0] instruccion;
  logic [3:0]    count;
  logic [7:0]    issued;

  always #5 clk = ~clk;

  secuenciador #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .start       (start),
    .instruccion (instruccion),
    .instr_valid (instr_valid),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .issued      (issued)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_iv = 0;
  bit mchk = 0;

  // Reference model: queue contents plus the cycle numbers at which load/issue/done are due.
  logic [IW-1:0] mq[$];
  logic [IW-1:0] m_cur = '0, m_last = '0;
  logic [7:0]    m_iss = '0;
  bit            m_active = 0;
  int            cyc = 0;
  int            m_load_at = -1, m_issue_at = -1, m_done_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int hz(input logic [IW-1:0] n, input logic [IW-1:0] p);
`ifdef SECUENCIADOR_HAZARD_EN
    return (p[3] && (n[18:14] == p[8:4] || n[13:9] == p[8:4])) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [IW-1:0] rnd_instr();
    logic [IW-1:0] r;
    r = IW'($urandom);
    r[18:14] = 5'($urandom_range(0, 3));
    r[13:9]  = 5'($urandom_range(0, 3));
    r[8:4]   = 5'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic model_check();
    bit iv_e;
    iv_e = (cyc == m_issue_at);
    chk("instr_valid", 32'(instr_valid), 32'(iv_e));
    chk("instruccion", 32'(instruccion), iv_e ? 32'(m_cur) : 32'd0);
    chk("done", 32'(done), 32'(cyc == m_done_at));
    chk("busy", 32'(busy), 32'(m_active));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
    chk("issued", 32'(issued), 32'(m_iss));
  endtask

  task automatic model_update();
    int sz0;
    bit start_ok, push_ok;
    if (rst) begin
      mq.delete();
      m_cur = '0; m_last = '0; m_iss = '0; m_active = 0;
      m_load_at = -1; m_issue_at = -1; m_done_at = -1;
    end else begin
      sz0 = mq.size();
      start_ok = !m_active && start && sz0 > 0;
      push_ok = in_valid && sz0 < DEPTH;
      if (cyc == m_load_at) begin
        m_cur = mq.pop_front();
        m_issue_at = cyc + 1 + hz(m_cur, m_last);
      end
      if (cyc == m_issue_at) begin
        m_iss = m_iss + 8'd1;
        m_last = m_cur;
        if (sz0 > 0) m_load_at = cyc + 1;
        else m_done_at = cyc + 1;
      end
      if (cyc == m_done_at) m_active = 0;
      if (start_ok) begin
        m_active = 1;
        m_load_at = cyc + 1;
      end
      if (push_ok) mq.push_back(in_instr);
    end
    cyc++;
  endtask

  task automatic half_a();
    @(negedge clk);
    if (mchk) model_check();
    if (instr_valid === 1'b1) n_iv++;
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic idle_in();
    in_valid = 1'b0; start = 1'b0; in_instr = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_in();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int k;
    k = 0;
    idle_in();
    while (m_active && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(k < budget), 32'd1);
  endtask

  typedef struct {
    logic          iv;
    logic [IW-1:0] ins;
    logic          st;
    logic          e_rdy;
    logic [3:0]    e_cnt;
    logic          e_ival;
    logic [IW-1:0] e_ins;
    logic          e_busy;
    logic          e_done;
    logic [7:0]    e_iss;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, tstart;
    int tv[$];
    int pushed;
    logic [IW-1:0] a, b, c;
    a = 20'h12340; b = 20'h0ABC0; c = 20'hF0F00;
    //          iv    ins     st    rdy   cnt   ival  e_ins   busy  done  iss
    vecs[0]  = '{1'b1, a,     1'b0, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, b,     1'b0, 1'b1, 4'd1, 1'b0, 20'h0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, c,     1'b0, 1'b1, 4'd2, 1'b0, 20'h0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 20'h0, 1'b1, 1'b1, 4'd3, 1'b0, 20'h0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd3, 1'b0, 20'h0, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd2, 1'b1, a,     1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd2, 1'b0, 20'h0, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd1, 1'b1, b,     1'b1, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd1, 1'b0, 20'h0, 1'b1, 1'b0, 8'd2};
    vecs[9]  = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd0, 1'b1, c,     1'b1, 1'b0, 8'd2};
    vecs[10] = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd0, 1'b0, 20'h0, 1'b1, 1'b1, 8'd3};
    vecs[11] = '{1'b0, 20'h0, 1'b0, 1'b1, 4'd0, 1'b0, 20'h0, 1'b0, 1'b0, 8'd3};

    do_reset();
    do_reset();
    mchk = 1;

    // Three-instruction program, cycle by cycle.
    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_instr = vecs[i].ins; start = vecs[i].st;
      half_a();
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[i].e_rdy));
      chk("tbl_count", 32'(count), 32'(vecs[i].e_cnt));
      chk("tbl_instr_valid", 32'(instr_valid), 32'(vecs[i].e_ival));
      chk("tbl_instruccion", 32'(instruccion), 32'(vecs[i].e_ins));
      chk("tbl_busy", 32'(busy), 32'(vecs[i].e_busy));
      chk("tbl_done", 32'(done), 32'(vecs[i].e_done));
      chk("tbl_issued", 32'(issued), 32'(vecs[i].e_iss));
      half_b();
    end

    // RAW pair: stall only when the hazard option is built in.
    do_reset();
    in_valid = 1'b1; in_instr = 20'h00018; tick();
    in_instr = 20'h04000; tick();
    idle_in(); start = 1'b1;
    half_a(); tstart = cyc; half_b();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      half_a();
      if (instr_valid === 1'b1) tv.push_back(cyc);
      half_b();
    end
    chk("haz_issue_count", 32'(tv.size()), 32'd2);
    if (tv.size() >= 2) begin
      chk("haz_first_issue", 32'(tv[0] - tstart), 32'd2);
`ifdef SECUENCIADOR_HAZARD_EN
      chk("haz_gap", 32'(tv[1] - tv[0]), 32'd3);
`else
      chk("haz_gap", 32'(tv[1] - tv[0]), 32'd2);
`endif
    end

    // Overflow: nine pushes into eight entries.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = IW'(32'h100 * (i + 1));
      half_a();
      if (i == 8) chk("ovf_ready_at_9th", 32'(in_ready), 32'd0);
      half_b();
    end
    idle_in();
    half_a();
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_count", 32'(count), 32'd8);
    half_b();
    start = 1'b1; tick();
    run_to_idle("ovf_drain_timeout", 100);
    half_a();
    chk("ovf_issued", 32'(issued), 32'd8);
    half_b();

    // Reset while the second of four instructions is issuing.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = IW'(32'h11110 * (i + 1)); tick();
    end
    idle_in(); start = 1'b1; tick();
    idle_in();
    tick(); tick(); tick();
    rst = 1'b1;
    half_a();
    chk("rst_during_issue2", 32'(instr_valid), 32'd1);
    chk("rst_issue2_word", 32'(instruccion), 32'h22220);
    half_b();
    rst = 1'b0;
    half_a();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_instruccion", 32'(instruccion), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    half_b();
    tick(); tick();

    // 256 issues in one program with stray start pulses while busy.
    do_reset();
    pushed = 0;
    n0 = n_iv;
    for (int k = 0; k < 3000 && (pushed < 256 || m_active || k < 2); k++) begin
      in_valid = (pushed < 256);
      in_instr = rnd_instr();
      start = (k == 1) || (k % 37 == 5);
      if (in_valid && mq.size() < DEPTH) pushed++;
      tick();
    end
    idle_in();
    chk("wrap_finished", 32'(m_active), 32'd0);
    half_a();
    chk("wrap_issue_cycles", 32'(n_iv - n0), 32'd256);
    chk("wrap_issued", 32'(issued), 32'd0);
    half_b();

    // Random traffic.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 127) == 0);
      in_valid = $urandom_range(0, 1);
      in_instr = rnd_instr();
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    run_to_idle("rnd_drain_timeout", 200);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
